cc_levelsequencer: RTL and testbench

//  Drives the Current/Progress query bus of the combinational level map ROM. Consumes
//  its 8-bit row word (bit7..0 = lanes) on every scroll tick and builds an 8-row screen.

---
 rtl/cc_levelsequencer.sv | 133 +++++++++++++
 tb/tb_cc_levelsequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cc_levelsequencer.sv
// cc_levelsequencer: six-phase level walker driving the map ROM query bus and an 8-row scrolling screen (optional wrap-around: CC_LEVELSEQUENCER_LOOP_EN)
module cc_levelsequencer #(
    parameter logic [4:0] LEN_P1 = 5'd8,
    parameter logic [4:0] LEN_P2 = 5'd10,
    parameter logic [4:0] LEN_P3 = 5'd8,
    parameter logic [4:0] LEN_P4 = 5'd15,
    parameter logic [4:0] LEN_P5 = 5'd8,
    parameter logic [4:0] LEN_P6 = 5'd20
) (
    input  logic        CC_LEVELSEQUENCER_CLOCK_50,
    input  logic        CC_LEVELSEQUENCER_RESET_InLow,
    input  logic        CC_LEVELSEQUENCER_Start_InLow,
    input  logic        CC_LEVELSEQUENCER_Tick,
    input  logic        CC_LEVELSEQUENCER_Pause,
    input  logic        CC_LEVELSEQUENCER_Crash,
    input  logic [7:0]  CC_LEVELSEQUENCER_Lv_InBus,
    output logic [4:0]  CC_LEVELSEQUENCER_Progress,
    output logic [2:0]  CC_LEVELSEQUENCER_Current,
    output logic [63:0] CC_LEVELSEQUENCER_Screen_OutBus,
    output logic        CC_LEVELSEQUENCER_RowValid,
    output logic        CC_LEVELSEQUENCER_PhaseDone,
    output logic        CC_LEVELSEQUENCER_Win,
    output logic [3:0]  CC_LEVELSEQUENCER_Lap_OutBus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_WIN   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  prog_q, prog_d;
    logic [2:0]  cur_q, cur_d;
    logic [63:0] scr_q, scr_d;
    logic        rv_q, rv_d, pd_q, pd_d, win_q, win_d;
    logic [4:0]  len;
    logic        last;
`ifdef CC_LEVELSEQUENCER_LOOP_EN
    logic [3:0]  lap_q, lap_d;
`endif

    assign len  = cur_q == 3'd1 ? LEN_P1 :
                  cur_q == 3'd2 ? LEN_P2 :
                  cur_q == 3'd3 ? LEN_P3 :
                  cur_q == 3'd4 ? LEN_P4 :
                  cur_q == 3'd5 ? LEN_P5 : LEN_P6;
    assign last = prog_q >= len;

    // Next-state: Start overrides everything; in RUN, Pause beats Crash (even phases only) beats Tick
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        cur_d   = cur_q;
        scr_d   = scr_q;
        win_d   = win_q;
        rv_d    = 1'b0;
        pd_d    = 1'b0;
`ifdef CC_LEVELSEQUENCER_LOOP_EN
        lap_d   = lap_q;
`endif
        if (!CC_LEVELSEQUENCER_Start_InLow) begin
            state_d = S_RUN;
            cur_d   = 3'd1;
            prog_d  = 5'd1;
            scr_d   = '0;
            win_d   = 1'b0;
        end else if (state_q == S_PAUSE) begin
            state_d = CC_LEVELSEQUENCER_Pause ? S_PAUSE : S_RUN;
        end else if (state_q == S_RUN) begin
            if (CC_LEVELSEQUENCER_Pause) begin
                state_d = S_PAUSE;
            end else if (CC_LEVELSEQUENCER_Crash && !cur_q[0]) begin
                prog_d = 5'd1;
                scr_d  = '0;
            end else if (CC_LEVELSEQUENCER_Tick) begin
                scr_d = {scr_q[55:0], CC_LEVELSEQUENCER_Lv_InBus};
                rv_d  = 1'b1;
                pd_d  = last;
                prog_d = last ? 5'd1 : prog_q + 5'd1;
                cur_d  = last ? cur_q + 3'd1 : cur_q;
                if (last && cur_q == 3'd6) begin
`ifdef CC_LEVELSEQUENCER_LOOP_EN
                    cur_d = 3'd1;
                    lap_d = lap_q == 4'hF ? lap_q : lap_q + 4'd1;
`else
                    state_d = S_WIN;
                    cur_d   = 3'd0;
                    prog_d  = 5'd0;
                    win_d   = 1'b1;
`endif
                end
            end
        end
    end

    // State registers with asynchronous return to the blank/idle state
    always_ff @(posedge CC_LEVELSEQUENCER_CLOCK_50 or negedge CC_LEVELSEQUENCER_RESET_InLow) begin
        if (!CC_LEVELSEQUENCER_RESET_InLow) begin
            state_q <= S_IDLE;
            prog_q  <= '0;
            cur_q   <= '0;
            scr_q   <= '0;
            rv_q    <= 1'b0;
            pd_q    <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            cur_q   <= cur_d;
            scr_q   <= scr_d;
            rv_q    <= rv_d;
            pd_q    <= pd_d;
            win_q   <= win_d;
        end
    end

`ifdef CC_LEVELSEQUENCER_LOOP_EN
    // Lap counter survives Start; only reset clears it
    always_ff @(posedge CC_LEVELSEQUENCER_CLOCK_50 or negedge CC_LEVELSEQUENCER_RESET_InLow) begin
        if (!CC_LEVELSEQUENCER_RESET_InLow) lap_q <= '0;
        else lap_q <= lap_d;
    end
    assign CC_LEVELSEQUENCER_Lap_OutBus = lap_q;
`else
    assign CC_LEVELSEQUENCER_Lap_OutBus = 4'd0;
`endif

    assign CC_LEVELSEQUENCER_Progress       = prog_q;
    assign CC_LEVELSEQUENCER_Current        = cur_q;
    assign CC_LEVELSEQUENCER_Screen_OutBus  = scr_q;
    assign CC_LEVELSEQUENCER_RowValid       = rv_q;
    assign CC_LEVELSEQUENCER_PhaseDone      = pd_q;
    assign CC_LEVELSEQUENCER_Win            = win_q;
endmodule

// File: tb/tb_cc_levelsequencer.sv
// tb_cc_levelsequencer: directed self-checking bench for cc_levelsequencer
module tb_cc_levelsequencer;
    logic        clk = 1'b0, rst_n = 1'b0, start_n = 1'b1, tick = 1'b0, pause = 1'b0, crash = 1'b0;
    logic [7:0]  lv = 8'd0;
    logic [4:0]  prog;
    logic [2:0]  cur;
    logic [63:0] scr;
    logic        rv, pd, win;
    logic [3:0]  lap;
    int checks = 0, failures = 0;

    cc_levelsequencer dut (
        .CC_LEVELSEQUENCER_CLOCK_50(clk),
        .CC_LEVELSEQUENCER_RESET_InLow(rst_n),
        .CC_LEVELSEQUENCER_Start_InLow(start_n),
        .CC_LEVELSEQUENCER_Tick(tick),
        .CC_LEVELSEQUENCER_Pause(pause),
        .CC_LEVELSEQUENCER_Crash(crash),
        .CC_LEVELSEQUENCER_Lv_InBus(lv),
        .CC_LEVELSEQUENCER_Progress(prog),
        .CC_LEVELSEQUENCER_Current(cur),
        .CC_LEVELSEQUENCER_Screen_OutBus(scr),
        .CC_LEVELSEQUENCER_RowValid(rv),
        .CC_LEVELSEQUENCER_PhaseDone(pd),
        .CC_LEVELSEQUENCER_Win(win),
        .CC_LEVELSEQUENCER_Lap_OutBus(lap)
    );

    always #5 clk = ~clk;

    task automatic step(input logic s, input logic t, input logic p, input logic c, input logic [7:0] l);
        start_n = s; tick = t; pause = p; crash = c; lv = l;
        @(negedge clk);
        start_n = 1'b1; tick = 1'b0; pause = 1'b0; crash = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({cur, prog} !== 8'd0) begin failures++; $display("FAIL reset_cur_prog got=%0h exp=0", {cur, prog}); end
        checks++; if (scr !== 64'd0) begin failures++; $display("FAIL reset_screen got=%h exp=0", scr); end
        checks++; if ({rv, pd, win, lap} !== 7'd0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {rv, pd, win, lap}); end
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 1, 0, 0, 8'hFF);
        checks++; if ({cur, prog, rv} !== 9'd0 || scr !== 64'd0) begin failures++; $display("FAIL idle_tick got=%0h/%h exp=0", {cur, prog, rv}, scr); end
    endtask

    task automatic test_start;
        step(0, 0, 0, 0, 8'h00);
        checks++; if (cur !== 3'd1 || prog !== 5'd1) begin failures++; $display("FAIL start_pos got=%0d/%0d exp=1/1", cur, prog); end
        checks++; if (scr !== 64'd0 || win !== 1'b0) begin failures++; $display("FAIL start_screen got=%h/%b exp=0/0", scr, win); end
    endtask

    task automatic test_phase1;
        int npd = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 8'hA5);
            npd += int'(pd);
            if (i == 0) begin
                checks++; if (rv !== 1'b1 || prog !== 5'd2) begin failures++; $display("FAIL first_tick got=rv%b/p%0d exp=rv1/p2", rv, prog); end
            end
        end
        checks++; if (scr !== {8{8'hA5}}) begin failures++; $display("FAIL phase1_screen got=%h exp=%h", scr, {8{8'hA5}}); end
        checks++; if (cur !== 3'd2 || prog !== 5'd1) begin failures++; $display("FAIL phase1_end got=%0d/%0d exp=2/1", cur, prog); end
        checks++; if (npd != 1) begin failures++; $display("FAIL phase1_pd got=%0d exp=1", npd); end
        step(1, 0, 0, 0, 8'h00);
        checks++; if (rv !== 1'b0 || pd !== 1'b0) begin failures++; $display("FAIL strobe_clear got=%b%b exp=00", rv, pd); end
    endtask

    task automatic test_crash;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 8'h3C);
        checks++; if (prog !== 5'd5) begin failures++; $display("FAIL pre_crash_prog got=%0d exp=5", prog); end
        step(1, 1, 0, 1, 8'hEE);
        checks++; if (prog !== 5'd1 || cur !== 3'd2) begin failures++; $display("FAIL crash_pos got=%0d/%0d exp=2/1", cur, prog); end
        checks++; if (scr !== 64'd0 || rv !== 1'b0) begin failures++; $display("FAIL crash_screen got=%h/%b exp=0/0", scr, rv); end
    endtask

    task automatic test_pause;
        step(1, 1, 0, 0, 8'h11);
        checks++; if (prog !== 5'd2 || scr !== 64'h11) begin failures++; $display("FAIL pre_pause got=%0d/%h exp=2/11", prog, scr); end
        step(1, 1, 1, 0, 8'h77);
        step(1, 1, 1, 1, 8'h77);
        step(1, 1, 1, 0, 8'h77);
        checks++; if (prog !== 5'd2 || scr !== 64'h11 || rv !== 1'b0) begin failures++; $display("FAIL paused got=%0d/%h/%b exp=2/11/0", prog, scr, rv); end
        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'h22);
        checks++; if (prog !== 5'd3 || scr !== 64'h1122) begin failures++; $display("FAIL resume got=%0d/%h exp=3/1122", prog, scr); end
    endtask

    task automatic test_full_run;
        int npd = 0;
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 69; i++) begin
            step(1, 1, 0, i == 3, 8'(i));
            npd += int'(pd);
            if (i == 3) begin
                checks++; if (prog !== 5'd5 || rv !== 1'b1) begin failures++; $display("FAIL odd_crash got=%0d/%b exp=5/1", prog, rv); end
            end
        end
        checks++; if (npd != 6) begin failures++; $display("FAIL run_pd got=%0d exp=6", npd); end
        checks++; if (scr !== 64'h3D3E3F4041424344) begin failures++; $display("FAIL run_screen got=%h exp=3d3e3f4041424344", scr); end
`ifdef CC_LEVELSEQUENCER_LOOP_EN
        checks++; if (cur !== 3'd1 || prog !== 5'd1 || win !== 1'b0 || lap !== 4'd1) begin failures++; $display("FAIL loop_end got=%0d/%0d/%b/%0d exp=1/1/0/1", cur, prog, win, lap); end
        step(0, 0, 0, 0, 8'h00);
        checks++; if (lap !== 4'd1) begin failures++; $display("FAIL lap_keep got=%0d exp=1", lap); end
`else
        checks++; if (cur !== 3'd0 || prog !== 5'd0 || win !== 1'b1 || lap !== 4'd0) begin failures++; $display("FAIL win_end got=%0d/%0d/%b/%0d exp=0/0/1/0", cur, prog, win, lap); end
        step(1, 1, 1, 1, 8'h99);
        step(1, 1, 0, 0, 8'h99);
        checks++; if (scr !== 64'h3D3E3F4041424344 || win !== 1'b1 || rv !== 1'b0 || prog !== 5'd0) begin failures++; $display("FAIL win_hold got=%h/%b/%b/%0d exp=3d3e3f4041424344/1/0/0", scr, win, rv, prog); end
`endif
    endtask

    task automatic test_reset_mid;
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 32; i++) step(1, 1, 0, 0, 8'h5A);
        checks++; if (cur !== 3'd4 || prog !== 5'd7) begin failures++; $display("FAIL pre_reset got=%0d/%0d exp=4/7", cur, prog); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({cur, prog, rv, pd, win, lap} !== 15'd0 || scr !== 64'd0) begin failures++; $display("FAIL async_reset got=%0h/%h exp=0/0", {cur, prog, rv, pd, win, lap}, scr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_start;
        test_phase1;
        test_crash;
        test_pause;
        test_full_run;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
